sequence_player: RTL
====================

Name: sequence_player

Overview:
- Plays a stored memory-game pattern to the player, one step at a time, by lighting one of 8 LEDs per step.
- Acts as the presenting end of the button-input path. It reads the same 3-bit step encoding that the input trimmer produces: 0..7 means LED/button 1..8.
- Pattern length is set by level, using the same step count the input side expects.
- Sits between pattern storage/generation and the LED drivers. The game controller starts it and waits for done before enabling input capture.

Parameters:
- ON_TICKS, 25_000_000: clock cycles each LED stays lit per step; must be ≥1.
- OFF_TICKS, 12_500_000: clock cycles of dark gap after each step; must be ≥1.
- CNT_W, 32: width of the internal tick counter; must hold max(ON_TICKS, OFF_TICKS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle request to begin playback; honoured only in IDLE.
- abort  in  1  stops playback immediately.
- level  in  3  difficulty, sampled on accepted start.
- seq_flat  in  48  16 steps × 3 bits; step k is in bits [3k+2:3k], with step 0 in bits [2:0]. Sampled on accepted start.
- led  out  8  one-hot LED drive; bit n lights LED n+1.
- busy  out  1  high while playback is in progress.
- step_idx  out  5  index of the step currently shown, 0..15.
- done  out  1  one-cycle pulse when a full playback completes.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, led=0, busy=0, step_idx=0, done=0, tick counter=0, latched pattern=0. Reset overrides every other input, including mid-playback.
- Step count N = 4 + 4*min(level,3): level 0→4, 1→8, 2→12, 3..7→16. Only steps 0..N-1 are played; the unused seq_flat bits are ignored.
- IDLE: led=0, busy=0. On start=1 and abort=0, latch seq_flat and N, set step_idx=0, load the counter with ON_TICKS-1, and go to ON. All outputs are registered, so at edge t+1 after the start cycle t: led=1<<seq[0] and busy=1.
- ON: led=1<<seq[step_idx]. The counter decrements each cycle. When it reaches 0, load OFF_TICKS-1 and go to OFF. The LED is lit for exactly ON_TICKS cycles.
- OFF: led=0 for exactly OFF_TICKS cycles. On expiry:
  - If step_idx==N-1: go to IDLE, busy=0, done=1 for that one cycle, step_idx held.
  - Otherwise: step_idx+1, load ON_TICKS-1, go to ON.
- Total busy duration is exactly N*(ON_TICKS+OFF_TICKS) cycles.
- done is high only in the first IDLE cycle after completion. A start in that same cycle is accepted, so back-to-back playback is allowed.
- start while busy is ignored; the latched pattern and level are not modified.
- abort=1 in ON or OFF: next edge gives IDLE, led=0, busy=0, done=0, step_idx=0. abort has priority over start in the same cycle. abort in IDLE has no effect.
- Changing seq_flat or level during playback has no effect, because both were latched at start.
- Consecutive equal steps (e.g. 3,3) remain distinguishable because of the mandatory OFF gap.
- led is never multi-hot. In IDLE and OFF, led==0.

Decomposition:
- Shared game package holds:
  - MAX_STEPS=16 and STEP_W=3;
  - the step-count function from level (shared with input capture so both ends agree);
  - the state encoding IDLE/ON/OFF;
  - the step→one-hot decode function.
- One sub-module, tick_timer: a load/decrement down-counter of width CNT_W with an `expired` flag. It is reused for both ON and OFF phases.

Test Plan (sim with ON_TICKS=4, OFF_TICKS=2):
- Full level-1 playback:
  - Stimulus: level=1, seq steps 0..7 = 0,7,2,5,1,6,3,4, start pulse.
  - Required: led shows 0x01,0x80,0x04,0x20,0x02,0x40,0x08,0x10, each 4 cycles, separated by 2 dark cycles; busy high exactly 48 cycles; done pulses once, 1 cycle later.
- Level clamp:
  - Stimulus: level=7, start.
  - Required: 16 steps played, step_idx reaches 15, busy=96 cycles; level=0 plays 4 steps (24 cycles).
- Start while busy:
  - Stimulus: during step 2, pulse start with a new seq_flat/level.
  - Required: playback continues unchanged with the original pattern; only one done.
- Abort:
  - Stimulus: abort during ON of step 3.
  - Required: next cycle led=0, busy=0, step_idx=0, no done pulse; a subsequent start replays from step 0.
- Back-to-back and repeats:
  - Stimulus: seq = 5,5,5,5 at level 0; start asserted in the done cycle.
  - Required: each 0x20 pulse is separated by 2 cycles of 0x00; the second playback starts at the edge after done.
- Reset mid-operation:
  - Stimulus: rst=1 for one cycle during OFF of step 1.
  - Required: all outputs 0 at the next edge; start/abort ignored while rst=1.

Source files
------------

// File: rtl/sequence_player_pkg.sv
// Shared memory-game definitions: step encoding, level-to-length rule, player states.
// Input capture uses the same step_count so both ends agree on pattern length.
package sequence_player_pkg;

  localparam int unsigned MAX_STEPS = 16;
  localparam int unsigned STEP_W    = 3;

  typedef enum logic [1:0] {
    StIdle,
    StOn,
    StOff
  } state_e;

  // Levels 3..7 all clamp to the full 16-step pattern.
  function automatic logic [4:0] step_count(input logic [2:0] level);
    if (level >= 3'd3) begin
      return 5'd16;
    end
    return 5'd4 + {1'b0, level[1:0], 2'b00};
  endfunction

  function automatic logic [7:0] step_onehot(input logic [STEP_W-1:0] step);
    return 8'b1 << step;
  endfunction

  function automatic logic [STEP_W-1:0] step_at(input logic [MAX_STEPS*STEP_W-1:0] seq,
                                                input logic [3:0] idx);
    logic [MAX_STEPS*STEP_W-1:0] sh;
    sh = seq >> (6'(idx) * 6'd3);
    return sh[STEP_W-1:0];
  endfunction

endpackage

// File: rtl/sequence_player_tick_timer.sv
// Load/decrement down-counter; expired_o is high while the count sits at zero.
module tick_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             expired_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (count_q == '0);

endmodule

// File: rtl/sequence_player.sv
// Presents a latched memory-game pattern on 8 one-hot LEDs, step by step, with a dark gap
// after every step so repeated steps stay distinguishable. All outputs are registered.
module sequence_player
  import sequence_player_pkg::*;
#(
  parameter int unsigned ON_TICKS  = 25_000_000,
  parameter int unsigned OFF_TICKS = 12_500_000,
  parameter int unsigned CNT_W     = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic [2:0]  level,
  input  logic [47:0] seq_flat,
  output logic [7:0]  led,
  output logic        busy,
  output logic [4:0]  step_idx,
  output logic        done
);

  state_e      state_q, state_d;
  logic [47:0] seq_q, seq_d;
  logic [4:0]  n_q, n_d;
  logic [4:0]  step_q, step_d;
  logic [7:0]  led_q, led_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expired;
  logic [4:0]       step_nxt;

  tick_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk_i     (clk),
    .rst_i     (rst),
    .load_i    (tmr_load),
    .load_val_i(tmr_val),
    .expired_o (tmr_expired)
  );

  assign step_nxt = step_q + 5'd1;

  always_comb begin
    state_d  = state_q;
    seq_d    = seq_q;
    n_d      = n_q;
    step_d   = step_q;
    led_d    = led_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      StIdle: begin
        led_d  = '0;
        busy_d = 1'b0;
        if (start && !abort) begin
          seq_d    = seq_flat;
          n_d      = step_count(level);
          step_d   = '0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(ON_TICKS - 1);
          state_d  = StOn;
          led_d    = step_onehot(seq_flat[STEP_W-1:0]);
          busy_d   = 1'b1;
        end
      end
      StOn, StOff: begin
        if (abort) begin
          // Clearing the timer keeps a later start from seeing a stale count.
          state_d  = StIdle;
          led_d    = '0;
          busy_d   = 1'b0;
          step_d   = '0;
          tmr_load = 1'b1;
        end else if (tmr_expired && state_q == StOn) begin
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(OFF_TICKS - 1);
          state_d  = StOff;
          led_d    = '0;
        end else if (tmr_expired) begin
          if (step_q == n_q - 5'd1) begin
            state_d = StIdle;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            step_d   = step_nxt;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(ON_TICKS - 1);
            state_d  = StOn;
            led_d    = step_onehot(step_at(seq_q, step_nxt[3:0]));
          end
        end
      end
      default: begin
        state_d = StIdle;
        led_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      seq_q   <= '0;
      n_q     <= '0;
      step_q  <= '0;
      led_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      n_q     <= n_d;
      step_q  <= step_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign step_idx = step_q;
  assign done     = done_q;

endmodule
